// File: rtl/apb_reg_initiator_if.sv
// APB slave-port bundle between the timer's APB master and apb_reg_initiator.
interface apb_reg_initiator_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_reg_initiator.sv
// APB-to-register-file bridge: one APB transfer becomes one wr_en/rd_en strobe,
// read data is captured one cycle after the strobe, then pready completes the
// access after WAIT_CYCLES extra cycles.
// Optional feature macro: APB_SLVERR_EN -- enables the address decode check
// (misaligned or above ADDR_LIMIT) answered with a one-cycle pslverr response.
module apb_reg_initiator #(
   parameter int                ADDR_W      = 10,
   parameter int                DATA_W      = 32,
   parameter int                WAIT_CYCLES = 0,
   parameter logic [ADDR_W-1:0] ADDR_LIMIT  = 'h00C
) (
   input  logic                 clk,
   input  logic                 rst,
   apb_reg_initiator_if.slave   apb,
   output logic                 wr_en,
   output logic                 rd_en,
   output logic [ADDR_W-1:0]    addr,
   output logic [DATA_W-1:0]    wdata,
   input  logic [DATA_W-1:0]    rdata
);

   typedef enum logic [2:0] {IDLE, ISSUE, LATCH, WAIT, RESP} state_t;

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t            state, state_nxt;
   logic              write_q;
   logic [DATA_W-1:0] prdata_q;
   logic [3:0]        wait_cnt;
   logic              setup;
   logic              dec_err;
   logic              abort;

   // Setup phase only; penable=1 seen in IDLE is an access phase we never saw start.
   assign setup = apb.psel & ~apb.penable;
   assign abort = ((state == ISSUE) || (state == LATCH) || (state == WAIT)) & ~apb.psel;

`ifdef APB_SLVERR_EN
   logic err_q;

   assign dec_err = (apb.paddr[1:0] != 2'b00) || (apb.paddr > ADDR_LIMIT);

   // Error flag: set by the decode at setup, dropped when the master abandons the transfer.
   always_ff @(posedge clk) begin
      if (rst)
         err_q <= 1'b0;
      else if ((state == IDLE) && setup)
         err_q <= dec_err;
      else if (abort)
         err_q <= 1'b0;
   end

   assign apb.pslverr = (state == RESP) & err_q;
`else
   assign dec_err     = 1'b0;
   assign apb.pslverr = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; psel dropping mid-transfer abandons it without a response.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (setup) state_nxt = dec_err ? RESP : ISSUE;
         ISSUE:   state_nxt = apb.psel ? LATCH : IDLE;
         LATCH: begin
            if (!apb.psel)            state_nxt = IDLE;
            else if (WAIT_CYCLES > 0) state_nxt = WAIT;
            else                      state_nxt = RESP;
         end
         WAIT: begin
            if (!apb.psel)          state_nxt = IDLE;
            else if (wait_cnt == 0) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Transfer capture, read-data latch and wait counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr     <= '0;
         wdata    <= '0;
         write_q  <= 1'b0;
         prdata_q <= '0;
         wait_cnt <= '0;
      end else begin
         // prdata is cleared here so writes and error responses return 0.
         if ((state == IDLE) && setup) begin
            addr     <= apb.paddr;
            wdata    <= apb.pwdata;
            write_q  <= apb.pwrite;
            prdata_q <= '0;
         end
         if ((state == LATCH) && apb.psel && !write_q)
            prdata_q <= rdata;
         if (state == LATCH)
            wait_cnt <= WAIT_LOAD;
         else if ((state == WAIT) && (wait_cnt != 0))
            wait_cnt <= wait_cnt - 4'd1;
      end
   end

   // Outputs decoded from registered state only.
   assign wr_en      = (state == ISSUE) &  write_q;
   assign rd_en      = (state == ISSUE) & ~write_q;
   assign apb.pready = (state == RESP);
   assign apb.prdata = prdata_q;

endmodule
